// File: rtl/fir_param.sv
// fir_param: parametrised, pipelined direct-form FIR filter with a writable
// coefficient bank, round-half-up scaling, output saturation and an overflow flag.
module fir_param #(
  parameter int unsigned N_TAPS = 11,
  parameter int unsigned DW     = 11,
  parameter int unsigned CW     = 11,
  parameter int unsigned OW     = 11,
  parameter int unsigned SHIFT  = 10
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic signed [DW-1:0]         DIN,
  input  logic                         VIN,
  input  logic                         CLEAR,
  input  logic                         CWE,
  input  logic [$clog2(N_TAPS)-1:0]    CADDR,
  input  logic signed [CW-1:0]         CDATA,
  output logic signed [OW-1:0]         DOUT,
  output logic                         VOUT,
  output logic                         OVF
);

  localparam int unsigned AB = $clog2(N_TAPS);
  localparam int unsigned PW = DW + CW;
  localparam int unsigned AW = DW + CW + $clog2(N_TAPS);
  localparam int unsigned RW = AW + 1;

  localparam logic signed [RW-1:0] RND  = RW'(1) <<< (SHIFT - 1);
  localparam logic signed [RW-1:0] MAXV = RW'(2 ** (OW - 1) - 1);
  localparam logic signed [RW-1:0] MINV = RW'(-(2 ** (OW - 1)));

  logic signed [DW-1:0] x [N_TAPS];
  logic signed [CW-1:0] c [N_TAPS];
  logic signed [PW-1:0] p [N_TAPS];
  logic signed [AW-1:0] acc;
  logic                 v1, v2, v3;

  logic signed [AW-1:0] sum_c;
  logic signed [RW-1:0] rnd_c;
  logic signed [OW-1:0] sat_c;
  logic                 ovf_c;

  // Coefficient bank; out-of-range addresses match no entry and are dropped
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_TAPS; i++) c[i] <= '0;
    end else if (CWE) begin
      for (int i = 0; i < N_TAPS; i++) begin
        if (CADDR == AB'(i)) c[i] <= CDATA;
      end
    end
  end

  // Stage 1: delay line shift on accepted samples; CLEAR flushes and wins over VIN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_TAPS; i++) x[i] <= '0;
      v1 <= 1'b0;
    end else if (CLEAR) begin
      for (int i = 0; i < N_TAPS; i++) x[i] <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= VIN;
      if (VIN) begin
        x[0] <= DIN;
        for (int i = 1; i < N_TAPS; i++) x[i] <= x[i-1];
      end
    end
  end

  // Stage 2: full-width per-tap products
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_TAPS; i++) p[i] <= '0;
      v2 <= 1'b0;
    end else begin
      for (int i = 0; i < N_TAPS; i++) p[i] <= PW'(x[i]) * PW'(c[i]);
      v2 <= CLEAR ? 1'b0 : v1;
    end
  end

  // Adder tree over sign-extended products; AW leaves headroom for every tap
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N_TAPS; i++) sum_c = sum_c + AW'(p[i]);
  end

  // Stage 3: accumulator register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc <= '0;
      v3  <= 1'b0;
    end else begin
      acc <= sum_c;
      v3  <= CLEAR ? 1'b0 : v2;
    end
  end

  // Round half up, arithmetic scale, then clamp to the output range
  always_comb begin
    rnd_c = (RW'(acc) + RND) >>> SHIFT;
    sat_c = rnd_c[OW-1:0];
    ovf_c = 1'b0;
    if (rnd_c > MAXV) begin
      sat_c = OW'(MAXV);
      ovf_c = 1'b1;
    end else if (rnd_c < MINV) begin
      sat_c = OW'(MINV);
      ovf_c = 1'b1;
    end
  end

  // Stage 4: registered outputs; DOUT holds between strobes, OVF only with VOUT
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOUT <= '0;
      VOUT <= 1'b0;
      OVF  <= 1'b0;
    end else if (CLEAR) begin
      VOUT <= 1'b0;
      OVF  <= 1'b0;
    end else begin
      VOUT <= v3;
      OVF  <= v3 & ovf_c;
      if (v3) DOUT <= sat_c;
    end
  end

endmodule

// File: tb/tb_fir_param.sv
// tb_fir_param: scenario tasks for fir_param checked against a sample-history
// reference model with a queue of expected outputs keyed by arrival cycle.
module tb_fir_param;

  localparam int unsigned N_TAPS = 11;
  localparam int unsigned DW     = 11;
  localparam int unsigned CW     = 11;
  localparam int unsigned OW     = 11;
  localparam int unsigned SHIFT  = 10;
  localparam int unsigned AB     = $clog2(N_TAPS);

  logic                  CLK;
  logic                  RST;
  logic signed [DW-1:0]  DIN;
  logic                  VIN;
  logic                  CLEAR;
  logic                  CWE;
  logic [AB-1:0]         CADDR;
  logic signed [CW-1:0]  CDATA;
  logic signed [OW-1:0]  DOUT;
  logic                  VOUT;
  logic                  OVF;

  fir_param #(
    .N_TAPS(N_TAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(SHIFT)
  ) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .VIN(VIN), .CLEAR(CLEAR), .CWE(CWE),
    .CADDR(CADDR), .CDATA(CDATA), .DOUT(DOUT), .VOUT(VOUT), .OVF(OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  typedef struct { int tgt; longint d; bit o; } exp_t;
  exp_t   q[$];
  longint hist [N_TAPS];
  longint coef [N_TAPS];
  int     cyc = 0;
  logic                 ev;
  logic                 eo;
  logic signed [OW-1:0] ed;

  function automatic void calc(input longint acc, output longint d, output bit o);
    longint r, mx, mn;
    r  = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    mx = (longint'(1) <<< (OW - 1)) - 1;
    mn = -(longint'(1) <<< (OW - 1));
    if (r > mx) begin d = mx; o = 1'b1; end
    else if (r < mn) begin d = mn; o = 1'b1; end
    else begin d = r; o = 1'b0; end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_TAPS; i++) begin hist[i] = 0; coef[i] = 0; end
    q.delete();
    ev = 1'b0; eo = 1'b0; ed = '0;
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, settle
  task automatic step(input bit vin, input int din, input bit clr,
                      input bit cwe, input int caddr, input int cdata);
    exp_t   e;
    longint acc, d;
    bit     o;
    VIN = vin; DIN = DW'(din); CLEAR = clr; CWE = cwe;
    CADDR = AB'(caddr); CDATA = CW'(cdata);
    @(posedge CLK);
    cyc++;
    if (cwe && caddr < N_TAPS) coef[caddr] = CDATA;
    ev = 1'b0; eo = 1'b0;
    if (clr) begin
      for (int i = 0; i < N_TAPS; i++) hist[i] = 0;
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].tgt == cyc) begin
        e = q.pop_front();
        ev = 1'b1; eo = e.o; ed = OW'(e.d);
      end
      if (vin) begin
        for (int i = N_TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = DIN;
        acc = 0;
        for (int i = 0; i < N_TAPS; i++) acc += hist[i] * coef[i];
        calc(acc, d, o);
        q.push_back('{tgt: cyc + 3, d: d, o: o});
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({VOUT, OVF, DOUT} !== {1'b0, 1'b0, OW'(0)}) begin
      n_fail++;
      $display("FAIL reset_state vout=%b ovf=%b dout=%0d required 0/0/0", VOUT, OVF, DOUT);
    end
    @(posedge CLK); @(posedge CLK); #3;
    RST = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step(0, 0, 0, 0, 0, 0);
      n_tests++;
      if ({VOUT, OVF, DOUT} !== {ev, eo, ed}) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d vout=%b ovf=%b dout=%0d required %b/%b/%0d", cyc, VOUT, OVF, DOUT, ev, eo, ed);
      end
    end
  endtask

  task automatic test_impulse();
    int got[$];
    int at[$];
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < N_TAPS; i++) step(0, 0, 0, 1, i, 64 * (i + 1));
    for (int s = 0; s < 17; s++) begin
      step(s < 14, (s == 0) ? 16 : 0, 0, 0, 0, 0);
      n_tests++;
      if ({VOUT, OVF, DOUT} !== {ev, eo, ed}) begin
        n_fail++;
        $display("FAIL impulse_model cyc=%0d vout=%b ovf=%b dout=%0d required %b/%b/%0d", cyc, VOUT, OVF, DOUT, ev, eo, ed);
      end
      if (VOUT) begin got.push_back(int'(DOUT)); at.push_back(s); end
    end
    n_tests++;
    if (got.size() != 14) begin
      n_fail++;
      $display("FAIL impulse_count strobes=%0d required 14", got.size());
    end
    for (int j = 0; j < got.size() && j < 14; j++) begin
      n_tests++;
      if (got[j] != ((j < 11) ? j + 1 : 0) || at[j] != j + 3) begin
        n_fail++;
        $display("FAIL impulse_seq idx=%0d dout=%0d at=%0d required %0d at %0d", j, got[j], at[j], (j < 11) ? j + 1 : 0, j + 3);
      end
    end
  endtask

  task automatic test_rounding();
    int din [4] = '{512, 511, -512, -513};
    int exp [4] = '{1, 0, 0, -1};
    step(0, 0, 1, 1, 0, 1);
    for (int i = 1; i < N_TAPS; i++) step(0, 0, 0, 1, i, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, din[k], 0, 0, 0, 0);
      for (int s = 0; s < 3; s++) begin
        step(0, 0, 0, 0, 0, 0);
        n_tests++;
        if ({VOUT, OVF, DOUT} !== {ev, eo, ed}) begin
          n_fail++;
          $display("FAIL rounding_model cyc=%0d vout=%b ovf=%b dout=%0d required %b/%b/%0d", cyc, VOUT, OVF, DOUT, ev, eo, ed);
        end
      end
      n_tests++;
      if (VOUT !== 1'b1 || int'(DOUT) != exp[k] || OVF !== 1'b0) begin
        n_fail++;
        $display("FAIL rounding din=%0d vout=%b dout=%0d ovf=%b required 1/%0d/0", din[k], VOUT, DOUT, OVF, exp[k]);
      end
    end
  endtask

  task automatic test_saturation();
    int din [2] = '{1023, -1024};
    for (int i = 0; i < N_TAPS; i++) step(0, 0, 0, 1, i, 1023);
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 17; s++) begin
        step(s < 14, din[k], 0, 0, 0, 0);
        n_tests++;
        if ({VOUT, OVF, DOUT} !== {ev, eo, ed}) begin
          n_fail++;
          $display("FAIL sat_model cyc=%0d vout=%b ovf=%b dout=%0d required %b/%b/%0d", cyc, VOUT, OVF, DOUT, ev, eo, ed);
        end
      end
      n_tests++;
      if (VOUT !== 1'b1 || int'(DOUT) != din[k] || OVF !== 1'b1) begin
        n_fail++;
        $display("FAIL saturation din=%0d vout=%b dout=%0d ovf=%b required 1/%0d/1", din[k], VOUT, DOUT, OVF, din[k]);
      end
      step(0, 0, 0, 0, 0, 0);
      n_tests++;
      if (VOUT !== 1'b0 || OVF !== 1'b0 || int'(DOUT) != din[k]) begin
        n_fail++;
        $display("FAIL sat_idle vout=%b ovf=%b dout=%0d required 0/0/%0d", VOUT, OVF, DOUT, din[k]);
      end
    end
  endtask

  task automatic test_vin_gaps();
    int got[$];
    int at[$];
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < N_TAPS; i++) step(0, 0, 0, 1, i, 64 * (i + 1));
    for (int s = 0; s < 36; s++) begin
      step((s % 3 == 0) && (s < 33), (s == 0) ? 16 : 0, 0, 0, 0, 0);
      n_tests++;
      if ({VOUT, OVF, DOUT} !== {ev, eo, ed}) begin
        n_fail++;
        $display("FAIL gaps_model cyc=%0d vout=%b ovf=%b dout=%0d required %b/%b/%0d", cyc, VOUT, OVF, DOUT, ev, eo, ed);
      end
      if (VOUT) begin got.push_back(int'(DOUT)); at.push_back(s); end
    end
    n_tests++;
    if (got.size() != 11) begin
      n_fail++;
      $display("FAIL gaps_count strobes=%0d required 11", got.size());
    end
    for (int j = 0; j < got.size() && j < 11; j++) begin
      n_tests++;
      if (got[j] != j + 1 || at[j] != 3 * j + 3) begin
        n_fail++;
        $display("FAIL gaps_seq idx=%0d dout=%0d at=%0d required %0d at %0d", j, got[j], at[j], j + 1, 3 * j + 3);
      end
    end
  endtask

  task automatic test_coef_clear();
    int got[$];
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < N_TAPS; i++) step(0, 0, 0, 1, i, 0);
    // Coefficient written on the same edge the sample is accepted
    step(1, 16, 0, 1, 0, 64);
    for (int s = 0; s < 3; s++) step(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (VOUT !== 1'b1 || int'(DOUT) != 1) begin
      n_fail++;
      $display("FAIL same_edge_write vout=%b dout=%0d required 1/1", VOUT, DOUT);
    end
    // Out-of-range address must not disturb any tap
    step(0, 0, 0, 1, 13, 500);
    for (int s = 0; s < 6; s++) begin
      step(s < 3, 16, 0, 0, 0, 0);
      n_tests++;
      if ({VOUT, OVF, DOUT} !== {ev, eo, ed}) begin
        n_fail++;
        $display("FAIL caddr_model cyc=%0d vout=%b ovf=%b dout=%0d required %b/%b/%0d", cyc, VOUT, OVF, DOUT, ev, eo, ed);
      end
    end
    n_tests++;
    if (VOUT !== 1'b1 || int'(DOUT) != 1) begin
      n_fail++;
      $display("FAIL caddr_oob vout=%b dout=%0d required 1/1", VOUT, DOUT);
    end
    // CLEAR with samples in flight, plus a simultaneous coefficient write
    step(1, 16, 0, 0, 0, 0);
    step(1, 16, 0, 0, 0, 0);
    step(1, 99, 1, 1, 1, 128);
    n_tests++;
    if (VOUT !== 1'b0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_vout vout=%b ovf=%b required 0/0", VOUT, OVF);
    end
    for (int s = 0; s < 9; s++) begin
      step((s >= 3) && (s < 6), (s == 3) ? 16 : 0, 0, 0, 0, 0);
      n_tests++;
      if ({VOUT, OVF, DOUT} !== {ev, eo, ed}) begin
        n_fail++;
        $display("FAIL clear_model cyc=%0d vout=%b ovf=%b dout=%0d required %b/%b/%0d", cyc, VOUT, OVF, DOUT, ev, eo, ed);
      end
      if (VOUT) got.push_back(int'(DOUT));
    end
    n_tests++;
    if (got.size() != 3 || got[0] != 1 || got[1] != 2 || got[2] != 0) begin
      n_fail++;
      $display("FAIL clear_response strobes=%0d first=%0d required 3 strobes 1,2,0", got.size(), (got.size() > 0) ? got[0] : -999);
    end
  endtask

  task automatic test_random();
    bit vin, clr, cwe;
    int din, caddr, cdata;
    for (int s = 0; s < 400; s++) begin
      vin   = ($urandom % 4) != 0;
      din   = int'($urandom_range(0, 2047)) - 1024;
      clr   = ($urandom % 60) == 0;
      cwe   = ($urandom % 6) == 0;
      caddr = int'($urandom % 16);
      cdata = (($urandom % 2) == 0) ? int'($urandom_range(0, 255)) - 128
                                    : int'($urandom_range(0, 2047)) - 1024;
      step(vin, din, clr, cwe, caddr, cdata);
      n_tests++;
      if ({VOUT, OVF, DOUT} !== {ev, eo, ed}) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d vout=%b ovf=%b dout=%0d required %b/%b/%0d", cyc, VOUT, OVF, DOUT, ev, eo, ed);
      end
    end
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    step(0, 0, 1, 1, 0, 64);
    for (int i = 1; i < N_TAPS; i++) step(0, 0, 0, 1, i, 0);
    for (int s = 0; s < 5; s++) begin
      step(1, 16, 0, 0, 0, 0);
      n_tests++;
      if ({VOUT, OVF, DOUT} !== {ev, eo, ed}) begin
        n_fail++;
        $display("FAIL pre_reset_model cyc=%0d vout=%b ovf=%b dout=%0d required %b/%b/%0d", cyc, VOUT, OVF, DOUT, ev, eo, ed);
      end
    end
    VIN = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if ({VOUT, OVF, DOUT} !== {1'b0, 1'b0, OW'(0)}) begin
      n_fail++;
      $display("FAIL reset_async vout=%b ovf=%b dout=%0d required 0/0/0", VOUT, OVF, DOUT);
    end
    @(posedge CLK); @(posedge CLK); #3;
    RST = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step(0, 0, 0, 0, 0, 0);
      if (VOUT) strobes++;
    end
    n_tests++;
    if (strobes != 0) begin
      n_fail++;
      $display("FAIL reset_stray strobes=%0d required 0", strobes);
    end
    step(1, 16, 0, 0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      step(0, 0, 0, 0, 0, 0);
      n_tests++;
      if ({VOUT, OVF, DOUT} !== {ev, eo, ed}) begin
        n_fail++;
        $display("FAIL post_reset_model cyc=%0d vout=%b ovf=%b dout=%0d required %b/%b/%0d", cyc, VOUT, OVF, DOUT, ev, eo, ed);
      end
    end
    n_tests++;
    if (VOUT !== 1'b1 || int'(DOUT) != 0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_coef_zero vout=%b dout=%0d ovf=%b required 1/0/0", VOUT, DOUT, OVF);
    end
  endtask

  initial begin
    RST = 1'b1; VIN = 1'b0; DIN = '0; CLEAR = 1'b0; CWE = 1'b0; CADDR = '0; CDATA = '0;
    model_reset();
    test_reset();
    test_impulse();
    test_rounding();
    test_saturation();
    test_vin_gaps();
    test_coef_clear();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
